wbupsz_merge: RTL

- Wishbone pipelined width upsizer: bridges a SMALL_DW slave port onto a WIDE_DW master port.
- Successor to the plain upsizer, with three additions:
  - configurable tracking-FIFO depth;
  - opportunistic write coalescing: small writes to the same wide word, arriving while the wide request is stalled, merge into one wide write;
  - per-request small acks regenerated from the merge counts.
- Sits between narrow CPU/DMA masters and the wide memory/SATA data bus.

---
 rtl/wbupsz_merge.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/wbupsz_merge.sv
// Wishbone pipelined width upsizer with write coalescing and regenerated small acks.
// Define WBUPSZ_MERGE_ERRADDR_EN to capture the small address of a failing request.
module wbupsz_merge #(
    parameter int unsigned ADDRESS_WIDTH     = 28,
    parameter int unsigned WIDE_DW           = 512,
    parameter int unsigned SMALL_DW          = 32,
    parameter int unsigned LGFIFO            = 5,
    parameter bit          OPT_LITTLE_ENDIAN = 1'b0,
    parameter bit          OPT_LOWPOWER      = 1'b0,
    parameter int unsigned MAXMERGE          = WIDE_DW / SMALL_DW
) (
    input  logic                                        i_clk,
    input  logic                                        i_reset,
    input  logic                                        i_scyc,
    input  logic                                        i_sstb,
    input  logic                                        i_swe,
    input  logic [ADDRESS_WIDTH-$clog2(SMALL_DW/8)-1:0] i_saddr,
    input  logic [SMALL_DW-1:0]                         i_sdata,
    input  logic [SMALL_DW/8-1:0]                       i_ssel,
    output logic                                        o_sstall,
    output logic                                        o_sack,
    output logic                                        o_serr,
    output logic [SMALL_DW-1:0]                         o_sdata,
    output logic                                        o_wcyc,
    output logic                                        o_wstb,
    output logic                                        o_wwe,
    output logic [ADDRESS_WIDTH-$clog2(WIDE_DW/8)-1:0]  o_waddr,
    output logic [WIDE_DW-1:0]                          o_wdata,
    output logic [WIDE_DW/8-1:0]                        o_wsel,
    input  logic                                        i_wstall,
    input  logic                                        i_wack,
    input  logic                                        i_werr,
    input  logic [WIDE_DW-1:0]                          i_wdata,
    output logic [ADDRESS_WIDTH-$clog2(SMALL_DW/8)-1:0] o_erraddr
);

    localparam int unsigned RATIO   = WIDE_DW / SMALL_DW;
    localparam int unsigned LGRATIO = $clog2(RATIO);
    localparam int unsigned SAW     = ADDRESS_WIDTH - $clog2(SMALL_DW / 8);
    localparam int unsigned WAW     = ADDRESS_WIDTH - $clog2(WIDE_DW / 8);
    localparam int unsigned SSW     = SMALL_DW / 8;
    localparam int unsigned WSW     = WIDE_DW / 8;
    localparam int unsigned CNTW    = $clog2(MAXMERGE + 1);
    localparam int unsigned CW      = LGFIFO + LGRATIO + 1;
    localparam int unsigned EW      = LGRATIO + CNTW;
    localparam int unsigned DEPTH   = 1 << LGFIFO;

    logic               flush, accept, drain, merge_ok, same_word, read_hold;
    logic               fifo_full, fifo_empty, push, pop;
    logic [LGRATIO-1:0] shift, lane, pop_shift, rd_lane;
    logic [CNTW-1:0]    pop_cnt;
    logic [WIDE_DW-1:0] new_data, merged_data;
    logic [WSW-1:0]     new_sel;

    logic               r_stb, r_we, r_wcyc, r_sack, r_serr;
    logic [WAW-1:0]     r_addr;
    logic [LGRATIO-1:0] r_shift;
    logic [WIDE_DW-1:0] r_data;
    logic [WSW-1:0]     r_sel;
    logic [CNTW-1:0]    r_cnt;
    logic [SMALL_DW-1:0] r_sdata;

    logic [EW-1:0]      fifo_mem [DEPTH];
    logic [LGFIFO-1:0]  wr_ptr, rd_ptr;
    logic [LGFIFO:0]    fill;
    logic [CW-1:0]      extra, extra_d, backlog, backlog_d;

    assign shift    = i_saddr[LGRATIO-1:0];
    assign lane     = OPT_LITTLE_ENDIAN ? shift : ~shift;
    assign new_data = WIDE_DW'(i_sdata) << (lane * SMALL_DW);
    assign new_sel  = WSW'(i_ssel) << (lane * SSW);

    always_comb begin
        merged_data = r_data;
        for (int b = 0; b < int'(WSW); b++) begin
            if (new_sel[b]) merged_data[8*b +: 8] = new_data[8*b +: 8];
        end
    end

    assign fifo_full  = fill[LGFIFO];
    assign fifo_empty = (fill == '0);
    assign o_wstb     = r_stb && !fifo_full;
    assign drain      = o_wstb && !i_wstall;
    assign same_word  = (r_addr == i_saddr[SAW-1:LGRATIO]);
    assign merge_ok   = r_stb && !drain && i_swe && r_we && same_word
                        && (r_cnt < CNTW'(MAXMERGE));
    // A merged write still in the holding register has acks owed too, so reads wait on it.
    assign read_hold  = !i_swe && ((extra != '0) || (backlog != '0)
                        || (r_stb && (r_cnt > CNTW'(1))));
    assign o_sstall   = (r_stb && (fifo_full || i_wstall) && !merge_ok) || read_hold;
    assign accept     = i_scyc && i_sstb && !o_sstall;
    assign flush      = i_reset || !i_scyc || r_serr || (r_wcyc && i_werr);
    assign push       = drain;
    assign pop        = i_wack && r_wcyc && !fifo_empty;
    assign {pop_shift, pop_cnt} = fifo_mem[rd_ptr];
    assign rd_lane    = OPT_LITTLE_ENDIAN ? pop_shift : ~pop_shift;

    always_ff @(posedge i_clk) begin
        if (flush) begin
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
        end else if (accept && !merge_ok) begin
            r_stb   <= 1'b1;
            r_we    <= i_swe;
            r_addr  <= i_saddr[SAW-1:LGRATIO];
            r_shift <= shift;
            r_data  <= new_data;
            r_sel   <= new_sel;
            r_cnt   <= CNTW'(1);
        end else if (accept) begin
            r_data  <= merged_data;
            r_sel   <= r_sel | new_sel;
            r_cnt   <= r_cnt + CNTW'(1);
        end else if (drain) begin
            r_stb   <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr] <= {r_shift, r_cnt};
    end

    always_ff @(posedge i_clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fill <= fill + 1'b1;
            else if (!push && pop) fill <= fill - 1'b1;
        end
    end

    // Popped merge counts move from "in flight" to "owed as regenerated acks".
    always_comb begin
        extra_d   = extra;
        backlog_d = backlog;
        if (push) extra_d = extra_d + CW'(r_cnt) - CW'(1);
        if (pop) begin
            extra_d   = extra_d - CW'(pop_cnt) + CW'(1);
            backlog_d = backlog + CW'(pop_cnt) - CW'(1);
        end else if (backlog != '0) begin
            backlog_d = backlog - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (flush) begin
            extra   <= '0;
            backlog <= '0;
            r_sack  <= 1'b0;
            r_wcyc  <= 1'b0;
            r_sdata <= '0;
        end else begin
            extra   <= extra_d;
            backlog <= backlog_d;
            r_sack  <= pop || (backlog != '0);
            if (accept) r_wcyc <= 1'b1;
            if (pop)               r_sdata <= i_wdata[rd_lane*SMALL_DW +: SMALL_DW];
            else if (OPT_LOWPOWER) r_sdata <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || !i_scyc) r_serr <= 1'b0;
        else                    r_serr <= r_wcyc && i_werr;
    end

    assign o_sack  = r_sack;
    assign o_serr  = r_serr;
    assign o_sdata = r_sdata;
    assign o_wcyc  = r_wcyc;
    assign o_wwe   = r_we;
    assign o_waddr = r_addr;
    assign o_wdata = (OPT_LOWPOWER && !o_wstb) ? '0 : r_data;
    assign o_wsel  = (OPT_LOWPOWER && !o_wstb) ? '0 : r_sel;

`ifdef WBUPSZ_MERGE_ERRADDR_EN
    logic [WAW-1:0] afifo [DEPTH];
    logic [SAW-1:0] r_erraddr;
    logic           r_errclr;

    always_ff @(posedge i_clk) begin
        if (push) afifo[wr_ptr] <= r_addr;
    end

    // The captured address survives the cycle drop; only a fresh request clears it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_erraddr <= '0;
            r_errclr  <= 1'b0;
        end else begin
            if (r_wcyc && i_werr && !fifo_empty) r_erraddr <= {afifo[rd_ptr], pop_shift};
            else if (accept && r_errclr)         r_erraddr <= '0;
            if (!i_scyc)     r_errclr <= 1'b1;
            else if (accept) r_errclr <= 1'b0;
        end
    end

    assign o_erraddr = r_erraddr;
`else
    assign o_erraddr = '0;
`endif

endmodule
